// File: rtl/adc_phase_gen.sv
// adc_phase_gen: parametrised multi-phase clock-enable generator.
//
// Divides refclk by a run-time programmable ratio and produces NUM_CLKS square-wave
// enables spaced evenly in phase. Each output can be nudged by one refclk cycle at a
// time. A lock flag asserts after LOCK_PERIODS complete output periods.
//
// Ports:
//   refclk        sole clock
//   rst           synchronous, active-high reset
//   cfg_valid_i   new divide request
//   cfg_div_i     requested divide ratio (values below 2 are treated as 2)
//   cfg_ready_o   divide request can be accepted
//   ps_valid_i    phase-step request
//   ps_sel_i      output index to step (out-of-range indices are ignored)
//   ps_updn_i     1 = delay one cycle (phase +1), 0 = advance (phase -1)
//   ps_ready_o    phase-step request can be accepted
//   outclk_o      divided square-wave enables
//   outstb_o      one-cycle pulse at each output's rising position
//   locked_o      outputs stable for LOCK_PERIODS periods
module adc_phase_gen #(
    parameter int unsigned NUM_CLKS     = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DEFAULT_DIV  = 10,
    parameter int unsigned LOCK_PERIODS = 4,
    localparam int unsigned SEL_W       = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid_i,
    input  logic [CNT_W-1:0]    cfg_div_i,
    output logic                cfg_ready_o,
    input  logic                ps_valid_i,
    input  logic [SEL_W-1:0]    ps_sel_i,
    input  logic                ps_updn_i,
    output logic                ps_ready_o,
    output logic [NUM_CLKS-1:0] outclk_o,
    output logic [NUM_CLKS-1:0] outstb_o,
    output logic                locked_o
);

    localparam int unsigned LOG_N  = $clog2(NUM_CLKS);
    localparam int unsigned PROD_W = CNT_W + LOG_N;
    localparam int unsigned PER_W  = $clog2(LOCK_PERIODS + 1);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [PER_W-1:0] PER_MAX = PER_W'(LOCK_PERIODS);

    // Even phase spread: floor(k * d / NUM_CLKS); NUM_CLKS is a power of two.
    function automatic logic [CNT_W-1:0] spread(input logic [CNT_W-1:0] d, input int unsigned k);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(k) * PROD_W'(d);
        return CNT_W'(prod >> LOG_N);
    endfunction

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    pend_div_q, pend_div_d;
    logic [CNT_W-1:0]    ph_q [NUM_CLKS];
    logic [CNT_W-1:0]    ph_d [NUM_CLKS];
    logic                cfg_pending_q, cfg_pending_d;
    logic [PER_W-1:0]    per_cnt_q, per_cnt_d;
    logic                locked_q, locked_d;
    logic [NUM_CLKS-1:0] outclk_q, outclk_d;
    logic [NUM_CLKS-1:0] outstb_q, outstb_d;

    logic                wrap;
    logic                cfg_xfer;
    logic                ps_xfer;
    logic [CNT_W-1:0]    half;
    logic [CNT_W-1:0]    pos [NUM_CLKS];

    assign cfg_ready_o = ~cfg_pending_q;
    assign ps_ready_o  = ~cfg_pending_q;
    assign outclk_o    = outclk_q;
    assign outstb_o    = outstb_q;
    assign locked_o    = locked_q;

    always_comb begin
        wrap     = (cnt_q == div_q - ONE);
        cfg_xfer = cfg_valid_i & ~cfg_pending_q;
        ps_xfer  = ps_valid_i & ~cfg_pending_q;
        half     = div_q >> 1;

        cnt_d         = cnt_q + ONE;
        div_d         = div_q;
        pend_div_d    = pend_div_q;
        cfg_pending_d = cfg_pending_q;
        per_cnt_d     = per_cnt_q;
        locked_d      = locked_q | (per_cnt_q == PER_MAX);
        outclk_d      = '0;
        outstb_d      = '0;

        for (int k = 0; k < NUM_CLKS; k++) begin
            ph_d[k] = ph_q[k];
            // (cnt - ph) mod div; the CNT_W wrap-around cancels since the result is < div.
            pos[k] = (cnt_q >= ph_q[k]) ? (cnt_q - ph_q[k]) : (cnt_q + (div_q - ph_q[k]));
            outclk_d[k] = (pos[k] < half);
            outstb_d[k] = (pos[k] == '0);
        end

        if (wrap) begin
            cnt_d = '0;
            if (per_cnt_q != PER_MAX) begin
                per_cnt_d = per_cnt_q + PER_W'(1);
            end
        end

        for (int k = 0; k < NUM_CLKS; k++) begin
            if (ps_xfer && (ps_sel_i == SEL_W'(k))) begin
                if (ps_updn_i) begin
                    ph_d[k] = (ph_q[k] == div_q - ONE) ? '0 : ph_q[k] + ONE;
                end else begin
                    ph_d[k] = (ph_q[k] == '0) ? div_q - ONE : ph_q[k] - ONE;
                end
            end
        end

        if (cfg_xfer) begin
            pend_div_d    = (cfg_div_i < TWO) ? TWO : cfg_div_i;
            cfg_pending_d = 1'b1;
        end

        // Applying a new ratio restarts the waveform and discards any phase steps.
        if (wrap && cfg_pending_q) begin
            div_d         = pend_div_q;
            cnt_d         = '0;
            cfg_pending_d = 1'b0;
            per_cnt_d     = '0;
            locked_d      = 1'b0;
            for (int k = 0; k < NUM_CLKS; k++) begin
                ph_d[k] = spread(pend_div_q, k);
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cnt_q         <= '0;
            div_q         <= DEF_DIV;
            pend_div_q    <= DEF_DIV;
            cfg_pending_q <= 1'b0;
            per_cnt_q     <= '0;
            locked_q      <= 1'b0;
            outclk_q      <= '0;
            outstb_q      <= '0;
            for (int k = 0; k < NUM_CLKS; k++) begin
                ph_q[k] <= spread(DEF_DIV, k);
            end
        end else begin
            cnt_q         <= cnt_d;
            div_q         <= div_d;
            pend_div_q    <= pend_div_d;
            cfg_pending_q <= cfg_pending_d;
            per_cnt_q     <= per_cnt_d;
            locked_q      <= locked_d;
            outclk_q      <= outclk_d;
            outstb_q      <= outstb_d;
            for (int k = 0; k < NUM_CLKS; k++) begin
                ph_q[k] <= ph_d[k];
            end
        end
    end

endmodule
